// File: rtl/decoder_pipe_pkg.sv
// decoder_pipe_pkg: opcode, ALU-op and write-back mux encodings shared by the
// decode pipe, plus the packed control struct stored in every queue entry.
// Branch fields exist only when DECODER_BRANCH_EN is defined.
package decoder_pipe_pkg;

    // Opcodes, held 32 bits wide so they compare against a zero-extended opcode
    localparam logic [31:0] OP_LOAD  = 32'd0;
    localparam logic [31:0] OP_STORE = 32'd1;
    localparam logic [31:0] OP_ADD   = 32'd2;
    localparam logic [31:0] OP_SUB   = 32'd3;
    localparam logic [31:0] OP_MUL   = 32'd4;
    localparam logic [31:0] OP_DIV   = 32'd5;
    localparam logic [31:0] OP_AND   = 32'd6;
    localparam logic [31:0] OP_ORR   = 32'd7;
    localparam logic [31:0] OP_CONST = 32'd8;
    localparam logic [31:0] OP_RET   = 32'd9;
    localparam logic [31:0] OP_BRA   = 32'd10;
    localparam logic [31:0] OP_BRZ   = 32'd11;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_MUL = 3'd2;
    localparam logic [2:0] ALU_DIV = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_ORR = 3'd5;

    // Register write-back source select
    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;

    // Control part of a decoded bundle (most significant part of a queue entry)
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       ret;
        logic       illegal;
`ifdef DECODER_BRANCH_EN
        logic       branch;
        logic       branch_cond;
`endif
        logic [1:0] wb_mux;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/decode_bundle_fifo.sv
// decode_bundle_fifo: generic 2-entry FIFO with synchronous flush.
// The head word reads as zero whenever the FIFO is empty, so consumers can
// use it directly as a quiet output bus.
module decode_bundle_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             push_s;
    logic             pop_s;

    assign push_s = push && (count_r != 2'd2);
    assign pop_s  = pop && (count_r != 2'd0);
    assign count  = count_r;

    // Storage, pointers and occupancy; flush wins over any push or pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head word, forced to zero while empty
    always_comb begin
        rdata = '0;
        if (count_r != 2'd0) begin
            rdata = mem_r[rd_ptr_r];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: decodes tagged instructions into control bundles and buffers
// them in a 2-entry queue toward the register-read/ALU stage.
// Optional macro DECODER_BRANCH_EN: makes BRA/BRZ legal and adds the
// out_branch / out_branch_cond ports.
module decoder_pipe #(
    parameter int  OPCODE_WIDTH      = 6,
    parameter int  REG_ADDR_WIDTH    = 7,
    parameter int  INSTRUCTION_WIDTH = 32,
    parameter int  DATA_WIDTH        = 32,
    parameter int  NUM_WARPS         = 4,
    localparam int WARP_ID_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int IMM_WIDTH         = INSTRUCTION_WIDTH - OPCODE_WIDTH - REG_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] in_instr,
    input  logic [WARP_ID_WIDTH-1:0]     in_warp,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_reg_write,
    output logic                         out_mem_read,
    output logic                         out_mem_write,
    output logic                         out_ret,
    output logic                         out_illegal,
`ifdef DECODER_BRANCH_EN
    output logic                         out_branch,
    output logic                         out_branch_cond,
`endif
    output logic [1:0]                   out_reg_write_mux,
    output logic [2:0]                   out_alu_op,
    output logic [REG_ADDR_WIDTH-1:0]    out_rd,
    output logic [REG_ADDR_WIDTH-1:0]    out_rm,
    output logic [REG_ADDR_WIDTH-1:0]    out_rn,
    output logic [DATA_WIDTH-1:0]        out_imm,
    output logic [WARP_ID_WIDTH-1:0]     out_warp,
    output logic [15:0]                  decode_count
);

    import decoder_pipe_pkg::*;

    localparam int BUNDLE_W = CTRL_W + WARP_ID_WIDTH + 3 * REG_ADDR_WIDTH + DATA_WIDTH;

    logic [OPCODE_WIDTH-1:0]   opcode_s;
    logic [31:0]               op_ext_s;
    logic [REG_ADDR_WIDTH-1:0] rd_s;
    logic [REG_ADDR_WIDTH-1:0] rm_s;
    logic [REG_ADDR_WIDTH-1:0] rn_s;
    logic [IMM_WIDTH-1:0]      imm_field_s;
    logic [DATA_WIDTH-1:0]     imm_s;
    ctrl_t                     ctrl_s;
    ctrl_t                     head_ctrl_s;
    logic [BUNDLE_W-1:0]       bundle_s;
    logic [BUNDLE_W-1:0]       head_s;
    logic [1:0]                count_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      ready_en_r;
    logic [15:0]               decode_count_r;

    // Field extraction: opcode in the MSBs, then rd, rm, rn; immediate in the LSBs
    assign opcode_s    = in_instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
    assign rd_s        = in_instr[INSTRUCTION_WIDTH-OPCODE_WIDTH-1 -: REG_ADDR_WIDTH];
    assign rm_s        = in_instr[INSTRUCTION_WIDTH-OPCODE_WIDTH-REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
    assign rn_s        = in_instr[INSTRUCTION_WIDTH-OPCODE_WIDTH-2*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
    assign imm_field_s = in_instr[IMM_WIDTH-1:0];
    assign imm_s       = DATA_WIDTH'($signed(imm_field_s));
    assign op_ext_s    = 32'(opcode_s);

    // Opcode to control flags; unknown opcodes raise only the illegal flag
    always_comb begin
        ctrl_s = '0;
        case (op_ext_s)
            OP_LOAD: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.wb_mux    = WB_MEM;
            end
            OP_STORE: ctrl_s.mem_write = 1'b1;
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_ORR: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.wb_mux    = WB_ALU;
                case (op_ext_s)
                    OP_SUB:  ctrl_s.alu_op = ALU_SUB;
                    OP_MUL:  ctrl_s.alu_op = ALU_MUL;
                    OP_DIV:  ctrl_s.alu_op = ALU_DIV;
                    OP_AND:  ctrl_s.alu_op = ALU_AND;
                    OP_ORR:  ctrl_s.alu_op = ALU_ORR;
                    default: ctrl_s.alu_op = ALU_ADD;
                endcase
            end
            OP_CONST: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.wb_mux    = WB_IMM;
            end
            OP_RET: ctrl_s.ret = 1'b1;
`ifdef DECODER_BRANCH_EN
            OP_BRA: ctrl_s.branch      = 1'b1;
            OP_BRZ: ctrl_s.branch_cond = 1'b1;
`endif
            default: ctrl_s.illegal = 1'b1;
        endcase
    end

    assign bundle_s  = {ctrl_s, in_warp, rd_s, rm_s, rn_s, imm_s};
    assign out_valid = (count_s != 2'd0);
    assign in_ready  = ready_en_r && (count_s != 2'd2) && !flush;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    decode_bundle_fifo #(
        .WIDTH (BUNDLE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (bundle_s),
        .rdata (head_s),
        .count (count_s)
    );

    // Head bundle unpacking; the FIFO zeroes it when empty
    assign {head_ctrl_s, out_warp, out_rd, out_rm, out_rn, out_imm} = head_s;
    assign out_reg_write     = head_ctrl_s.reg_write;
    assign out_mem_read      = head_ctrl_s.mem_read;
    assign out_mem_write     = head_ctrl_s.mem_write;
    assign out_ret           = head_ctrl_s.ret;
    assign out_illegal       = head_ctrl_s.illegal;
    assign out_reg_write_mux = head_ctrl_s.wb_mux;
    assign out_alu_op        = head_ctrl_s.alu_op;
`ifdef DECODER_BRANCH_EN
    assign out_branch        = head_ctrl_s.branch;
    assign out_branch_cond   = head_ctrl_s.branch_cond;
`endif
    assign decode_count      = decode_count_r;

    // Keeps in_ready low during reset and raises it from the first clock after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Counts accepted pushes (flush already blocks in_ready), wrapping at 16 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            decode_count_r <= 16'd0;
        end else if (push_s) begin
            decode_count_r <= decode_count_r + 16'd1;
        end else begin
            decode_count_r <= decode_count_r;
        end
    end

endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: directed plus random stimulus against a queue-based
// behavioural model of the decode pipe, compared every cycle.
module tb_decoder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [1:0]  in_warp = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_reg_write, out_mem_read, out_mem_write, out_ret, out_illegal;
`ifdef DECODER_BRANCH_EN
    logic        out_branch, out_branch_cond;
`endif
    logic [1:0]  out_reg_write_mux;
    logic [2:0]  out_alu_op;
    logic [6:0]  out_rd, out_rm, out_rn;
    logic [31:0] out_imm;
    logic [1:0]  out_warp;
    logic [15:0] decode_count;

    decoder_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_warp(in_warp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_ret(out_ret), .out_illegal(out_illegal),
`ifdef DECODER_BRANCH_EN
        .out_branch(out_branch), .out_branch_cond(out_branch_cond),
`endif
        .out_reg_write_mux(out_reg_write_mux), .out_alu_op(out_alu_op),
        .out_rd(out_rd), .out_rm(out_rm), .out_rn(out_rn),
        .out_imm(out_imm), .out_warp(out_warp), .decode_count(decode_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw, mr, mw, ret, ill;
`ifdef DECODER_BRANCH_EN
        logic        br, brc;
`endif
        logic [1:0]  mux;
        logic [2:0]  alu;
        logic [6:0]  rd, rm, rn;
        logic [31:0] imm;
        logic [1:0]  warp;
    } exp_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    exp_t        q[$];
    int unsigned cnt_m = 0;
    bit          rdy_m = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decoding rules expressed with plain integer arithmetic
    function automatic exp_t model_decode(input logic [31:0] w, input logic [1:0] warp);
        exp_t e;
        int   op;
        int   imm;
        e   = '0;
        op  = int'(w / 32'd67108864);
        e.rd = 7'((w / 32'd524288) % 32'd128);
        e.rm = 7'((w / 32'd4096) % 32'd128);
        e.rn = 7'((w / 32'd32) % 32'd128);
        imm = int'(w % 32'd524288);
        if (imm >= 262144) imm = imm - 524288;
        e.imm  = 32'(imm);
        e.warp = warp;
        if (op == 0) begin e.rw = 1'b1; e.mr = 1'b1; e.mux = 2'd0; end
        else if (op == 1) e.mw = 1'b1;
        else if (op >= 2 && op <= 7) begin e.rw = 1'b1; e.mux = 2'd1; e.alu = 3'(op - 2); end
        else if (op == 8) begin e.rw = 1'b1; e.mux = 2'd2; end
        else if (op == 9) e.ret = 1'b1;
`ifdef DECODER_BRANCH_EN
        else if (op == 10) e.br = 1'b1;
        else if (op == 11) e.brc = 1'b1;
`endif
        else e.ill = 1'b1;
        return e;
    endfunction

    // Model update on each clock edge or asynchronous reset
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                cnt_m = 0;
                rdy_m = 1'b0;
            end else begin
                bit acc;
                bit pop;
                acc = rdy_m && (q.size() < 2) && !flush && in_valid;
                pop = (q.size() != 0) && out_ready;
                if (!flush) begin
                    if (pop) void'(q.pop_front());
                    if (acc) begin
                        q.push_back(model_decode(in_instr, in_warp));
                        cnt_m++;
                    end
                end else begin
                    q.delete();
                end
                rdy_m = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model on the falling edge
    initial begin
        forever begin
            exp_t e, a;
            @(negedge clk);
            e = (q.size() != 0) ? q[0] : '0;
            a = '0;
            a.rw = out_reg_write; a.mr = out_mem_read; a.mw = out_mem_write;
            a.ret = out_ret; a.ill = out_illegal;
`ifdef DECODER_BRANCH_EN
            a.br = out_branch; a.brc = out_branch_cond;
`endif
            a.mux = out_reg_write_mux; a.alu = out_alu_op;
            a.rd = out_rd; a.rm = out_rm; a.rn = out_rn;
            a.imm = out_imm; a.warp = out_warp;
            chk("bundle", a, e);
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, rdy_m && (q.size() < 2) && !flush);
            chk("decode_count", decode_count, cnt_m % 65536);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic push1(input logic [31:0] w, input logic [1:0] warp);
        in_valid = 1'b1;
        in_instr = w;
        in_warp  = warp;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  op;

        // Reset state
        at_neg();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_count", decode_count, 16'd0);
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        at_neg();
        chk("ready_after_rst", in_ready, 1'b1);
        cyc();

        // SUB rd=3 rm=4 rn=5 warp=2
        out_ready = 1'b1;
        push1({6'd3, 7'd3, 7'd4, 7'd5, 5'd0}, 2'd2);
        at_neg();
        chk("sub_valid", out_valid, 1'b1);
        chk("sub_rw", out_reg_write, 1'b1);
        chk("sub_mux", out_reg_write_mux, 2'd1);
        chk("sub_alu", out_alu_op, 3'd1);
        chk("sub_regs", {out_rd, out_rm, out_rn}, {7'd3, 7'd4, 7'd5});
        chk("sub_warp", out_warp, 2'd2);
        chk("sub_count", decode_count, 16'd1);
        cyc();

        // CONST immediates, negative and positive
        push1({6'd8, 7'd1, 19'h7FFFF}, 2'd0);
        at_neg();
        chk("const_neg_imm", out_imm, 32'hFFFF_FFFF);
        chk("const_mux", out_reg_write_mux, 2'd2);
        cyc();
        push1({6'd8, 7'd1, 19'h00005}, 2'd1);
        at_neg();
        chk("const_pos_imm", out_imm, 32'd5);
        cyc();

        // Fill with LOAD, STORE; a third push is ignored; drain in order
        out_ready = 1'b0;
        push1({6'd0, 7'd1, 7'd2, 7'd3, 5'd0}, 2'd1);
        push1({6'd1, 7'd4, 7'd5, 7'd6, 5'd0}, 2'd3);
        in_valid = 1'b1;
        in_instr = {6'd2, 26'd0};
        cyc(); cyc();
        in_valid = 1'b0;
        at_neg();
        chk("full_ready", in_ready, 1'b0);
        chk("full_count", decode_count, 16'd5);
        cyc();
        out_ready = 1'b1;
        at_neg();
        chk("drain_load", out_mem_read, 1'b1);
        cyc();
        at_neg();
        chk("drain_store", out_mem_write, 1'b1);
        cyc();
        at_neg();
        chk("drain_empty", out_valid, 1'b0);
        cyc();

        // One entry held while pushing and popping every cycle for ten cycles
        out_ready = 1'b0;
        push1({6'd0, 7'd9, 7'd9, 7'd9, 5'd0}, 2'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_instr = {6'(2 + (i % 6)), 7'(i), 7'(i + 1), 7'(i + 2), 5'd0};
            in_warp  = 2'(i);
            cyc();
        end
        in_valid = 1'b0;
        at_neg();
        chk("pp_count", decode_count, 16'd16);
        chk("pp_valid", out_valid, 1'b1);
        cyc();

        // Illegal opcodes
        push1({6'h3F, 26'h3FF_FFFF}, 2'd0);
        at_neg();
        chk("ill_3f", out_illegal, 1'b1);
        chk("ill_3f_rw", out_reg_write, 1'b0);
        chk("ill_count", decode_count, 16'd17);
        cyc();
        push1({6'd10, 26'd0}, 2'd0);
        at_neg();
`ifdef DECODER_BRANCH_EN
        chk("op10_illegal", out_illegal, 1'b0);
`else
        chk("op10_illegal", out_illegal, 1'b1);
`endif
        cyc();

        // Flush a full queue while a push is offered
        out_ready = 1'b0;
        push1({6'd2, 26'd1}, 2'd0);
        push1({6'd3, 26'd2}, 2'd1);
        in_valid = 1'b1;
        flush    = 1'b1;
        at_neg();
        chk("flush_ready", in_ready, 1'b0);
        cyc();
        in_valid = 1'b0;
        flush    = 1'b0;
        at_neg();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_count", decode_count, 16'd20);
        cyc();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
            else op = 6'($urandom_range(0, 12));
            in_instr  = {op, r[25:0]};
            in_warp   = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cyc();
        end
        flush    = 1'b0;
        in_valid = 1'b0;

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        push1({6'd8, 7'd2, 19'h12345}, 2'd1);
        at_neg();
        chk("pre_rst_valid", out_valid, 1'b1);
        cyc();
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_imm", out_imm, 32'd0);
        chk("async_rst_count", decode_count, 16'd0);
        chk("async_rst_ready", in_ready, 1'b0);
        cyc(); cyc();
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            in_instr  = {6'($urandom_range(0, 12)), r[25:0]};
            in_warp   = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 1) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            cyc();
        end
        in_valid = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
